// File: rtl/seq_stage_controller.sv
// rtl/seq_stage_controller.sv - Y86 SEQ stage sequencer with condition codes, branch condition and status.
// One stage enable per cycle; memory-class instructions may stall in MEMORY until ready or timeout.
module seq_stage_controller #(
  parameter int COUNT_W     = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [3:0]         icode,
  input  logic [3:0]         ifun,
  input  logic               imem_error,
  input  logic               alu_zf,
  input  logic               alu_sf,
  input  logic               alu_of,
  input  logic               mem_ready,
  input  logic               dmem_error,
  output logic               fetch_en,
  output logic               decode_en,
  output logic               execute_en,
  output logic               memory_en,
  output logic               writeback_en,
  output logic               pcupd_en,
  output logic               mem_req,
  output logic               cc_zf,
  output logic               cc_sf,
  output logic               cc_of,
  output logic               cond,
  output logic [2:0]         stat,
  output logic               halted,
  output logic [COUNT_W-1:0] instr_count
);

  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  typedef enum logic [2:0] {
    S_START, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_PCUPD, S_HALT
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [2:0]         r_stat;
  logic [2:0]         w_stat_next;
  logic [WAIT_W-1:0]  r_wait;
  logic               r_cc_zf, r_cc_sf, r_cc_of;
  logic               r_cond;
  logic [COUNT_W-1:0] r_count;
  logic               w_mem_class;
  logic               w_lt;
  logic               w_cond_eval;

  assign w_mem_class = (icode == 4'h4) || (icode == 4'h5) || (icode == 4'h8) ||
                       (icode == 4'h9) || (icode == 4'hA) || (icode == 4'hB);

  // Branch/cmov condition uses the CC register as it stood before this EXECUTE edge.
  assign w_lt = r_cc_sf ^ r_cc_of;
  always_comb begin
    w_cond_eval = 1'b0;
    case (ifun)
      4'd0:    w_cond_eval = 1'b1;
      4'd1:    w_cond_eval = w_lt | r_cc_zf;
      4'd2:    w_cond_eval = w_lt;
      4'd3:    w_cond_eval = r_cc_zf;
      4'd4:    w_cond_eval = ~r_cc_zf;
      4'd5:    w_cond_eval = ~w_lt;
      4'd6:    w_cond_eval = ~w_lt & ~r_cc_zf;
      default: w_cond_eval = 1'b0;
    endcase
  end

  always_comb begin
    w_next       = r_state;
    w_stat_next  = r_stat;
    fetch_en     = 1'b0;
    decode_en    = 1'b0;
    execute_en   = 1'b0;
    memory_en    = 1'b0;
    writeback_en = 1'b0;
    pcupd_en     = 1'b0;
    mem_req      = 1'b0;
    case (r_state)
      S_START: w_next = S_FETCH;
      S_FETCH: begin
        fetch_en = 1'b1;
        if (imem_error) begin
          w_stat_next = STAT_ADR;
          w_next      = S_HALT;
        end else if (icode > 4'hB) begin
          w_stat_next = STAT_INS;
          w_next      = S_HALT;
        end else if (icode == 4'h0) begin
          w_stat_next = STAT_HLT;
          w_next      = S_HALT;
        end else begin
          w_next = S_DECODE;
        end
      end
      S_DECODE: begin
        decode_en = 1'b1;
        w_next    = S_EXECUTE;
      end
      S_EXECUTE: begin
        execute_en = 1'b1;
        w_next     = S_MEMORY;
      end
      S_MEMORY: begin
        memory_en = 1'b1;
        if (w_mem_class) begin
          mem_req = 1'b1;
          // A ready arriving on the final allowed cycle still completes normally.
          if (mem_ready) begin
            if (dmem_error) begin
              w_stat_next = STAT_ADR;
              w_next      = S_HALT;
            end else begin
              w_next = S_WRITEBACK;
            end
          end else if (r_wait == WAIT_LAST) begin
            w_stat_next = STAT_ADR;
            w_next      = S_HALT;
          end
        end else begin
          w_next = S_WRITEBACK;
        end
      end
      S_WRITEBACK: begin
        writeback_en = 1'b1;
        w_next       = S_PCUPD;
      end
      S_PCUPD: begin
        pcupd_en = 1'b1;
        w_next   = S_FETCH;
      end
      S_HALT:  w_next = S_HALT;
      default: w_next = S_START;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_START;
      r_stat  <= STAT_AOK;
      r_wait  <= '0;
      r_cc_zf <= 1'b1;
      r_cc_sf <= 1'b0;
      r_cc_of <= 1'b0;
      r_cond  <= 1'b0;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      r_stat  <= w_stat_next;
      r_wait  <= (r_state == S_MEMORY && w_next == S_MEMORY) ? r_wait + 1'b1 : '0;
      if (r_state == S_EXECUTE) begin
        if (icode == 4'h6) begin
          r_cc_zf <= alu_zf;
          r_cc_sf <= alu_sf;
          r_cc_of <= alu_of;
        end
        r_cond <= (icode == 4'h2 || icode == 4'h7) ? w_cond_eval : 1'b0;
      end
      if (r_state == S_PCUPD && r_count != '1)
        r_count <= r_count + 1'b1;
    end
  end

  assign cc_zf       = r_cc_zf;
  assign cc_sf       = r_cc_sf;
  assign cc_of       = r_cc_of;
  assign cond        = r_cond;
  assign stat        = r_stat;
  assign halted      = (r_state == S_HALT);
  assign instr_count = r_count;

endmodule

// File: tb/tb_seq_stage_controller.sv
// tb/tb_seq_stage_controller.sv - self-checking bench for seq_stage_controller.
// Instruction-level reference model; directed scenarios followed by randomized instruction streams.
module tb_seq_stage_controller;

  localparam int CW = 4;
  localparam int MT = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [3:0]    icode = 4'h0;
  logic [3:0]    ifun = 4'h0;
  logic          imem_error = 1'b0;
  logic          alu_zf = 1'b0, alu_sf = 1'b0, alu_of = 1'b0;
  logic          mem_ready = 1'b0, dmem_error = 1'b0;
  logic          fetch_en, decode_en, execute_en, memory_en, writeback_en, pcupd_en;
  logic          mem_req, cc_zf, cc_sf, cc_of, cond, halted;
  logic [2:0]    stat;
  logic [CW-1:0] instr_count;
  logic [5:0]    en;

  seq_stage_controller #(.COUNT_W(CW), .MEM_TIMEOUT(MT)) dut (
    .clock(clock), .reset(reset), .icode(icode), .ifun(ifun), .imem_error(imem_error),
    .alu_zf(alu_zf), .alu_sf(alu_sf), .alu_of(alu_of), .mem_ready(mem_ready),
    .dmem_error(dmem_error), .fetch_en(fetch_en), .decode_en(decode_en),
    .execute_en(execute_en), .memory_en(memory_en), .writeback_en(writeback_en),
    .pcupd_en(pcupd_en), .mem_req(mem_req), .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of),
    .cond(cond), .stat(stat), .halted(halted), .instr_count(instr_count)
  );

  assign en = {fetch_en, decode_en, execute_en, memory_en, writeback_en, pcupd_en};

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  bit [2:0] m_cc;
  bit       m_cond;
  int       m_stat;
  int       m_count;
  bit       m_halted;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit f_cond(input logic [3:0] fn, input bit [2:0] c);
    bit zf = c[2];
    bit sf = c[1];
    bit of = c[0];
    bit lt = (sf != of);
    case (fn)
      4'd0: return 1'b1;
      4'd1: return lt || zf;
      4'd2: return lt;
      4'd3: return zf;
      4'd4: return !zf;
      4'd5: return !lt;
      4'd6: return !lt && !zf;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check_arch(input string tag);
    chk({tag, "_cc"}, {cc_zf, cc_sf, cc_of}, m_cc);
    chk({tag, "_cond"}, cond, m_cond);
    chk({tag, "_stat"}, stat, m_stat);
    chk({tag, "_count"}, instr_count, m_count);
    chk({tag, "_halted"}, halted, m_halted);
  endtask

  task automatic model_reset();
    m_cc = 3'b100; m_cond = 0; m_stat = 1; m_count = 0; m_halted = 0;
  endtask

  // Leaves the bench at a negedge with the DUT in its first FETCH cycle.
  task automatic do_reset();
    reset = 1'b1;
    icode = 4'h0; ifun = 4'h0; imem_error = 0; mem_ready = 0; dmem_error = 0;
    model_reset();
    @(posedge clock);
    @(posedge clock);
    #1;
    chk("rst_en", en, 6'b0);
    chk("rst_mem_req", mem_req, 1'b0);
    check_arch("rst");
    reset = 1'b0;
    @(negedge clock);
    chk("start_idle", en, 6'b0);
    @(negedge clock);
    chk("first_fetch", en, 6'b100000);
  endtask

  // Entered and left at a negedge in a FETCH cycle (or in HALT after a fault).
  task automatic run_instr(input logic [3:0] ic, input logic [3:0] fn, input bit ierr,
                           input bit zf, input bit sf, input bit of,
                           input int rdy_k, input bit derr);
    int  cyc;
    int  k;
    bit  memc;
    bit  done;
    bit  fault;
    icode = ic; ifun = fn; imem_error = ierr;
    alu_zf = zf; alu_sf = sf; alu_of = of;
    mem_ready = 0; dmem_error = 0;
    chk("fetch", en, 6'b100000);
    cyc = 1;
    if (ierr || ic > 4'hB || ic == 4'h0) begin
      m_stat = ierr ? 3 : (ic > 4'hB ? 4 : 2);
      m_halted = 1;
      @(negedge clock);
      chk("halt_en", en, 6'b0);
      chk("halt_mem_req", mem_req, 1'b0);
      check_arch("fetch_halt");
      @(negedge clock);
      chk("halt_hold_en", en, 6'b0);
      check_arch("halt_hold");
      return;
    end
    @(negedge clock); cyc++;
    chk("decode", en, 6'b010000);
    @(negedge clock); cyc++;
    chk("execute", en, 6'b001000);
    m_cond = (ic == 4'h2 || ic == 4'h7) ? f_cond(fn, m_cc) : 1'b0;
    if (ic == 4'h6) m_cc = {zf, sf, of};
    memc = ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
    @(negedge clock); cyc++;
    check_arch("post_exec");
    k = 1; done = 0; fault = 0;
    while (!done) begin
      chk("memory", en, 6'b000100);
      chk("mem_req", mem_req, memc);
      if (!memc) done = 1;
      else if (k == rdy_k) begin
        mem_ready = 1; dmem_error = derr;
        fault = derr; done = 1;
      end else if (k == MT) begin
        fault = 1; done = 1;
      end else begin
        @(negedge clock); cyc++; k++;
      end
    end
    if (fault) begin
      m_stat = 3; m_halted = 1;
      @(negedge clock);
      mem_ready = 0; dmem_error = 0;
      chk("mem_halt_en", en, 6'b0);
      check_arch("mem_halt");
      return;
    end
    @(negedge clock); cyc++;
    mem_ready = 0; dmem_error = 0;
    chk("writeback", en, 6'b000010);
    @(negedge clock); cyc++;
    chk("pcupd", en, 6'b000001);
    @(negedge clock);
    if (m_count < (1 << CW) - 1) m_count++;
    chk("latency", cyc, memc ? 6 + rdy_k - 1 : 6);
    chk("next_fetch", en, 6'b100000);
    check_arch("retire");
  endtask

  initial begin
    do_reset();
    run_instr(4'h6, 4'h1, 0, 1, 0, 0, 0, 0);
    run_instr(4'h6, 4'h0, 0, 0, 1, 0, 0, 0);
    run_instr(4'h7, 4'h2, 0, 1, 1, 1, 0, 0);
    chk("jl_taken", cond, 1'b1);
    run_instr(4'h7, 4'h5, 0, 1, 1, 1, 0, 0);
    chk("jge_not", cond, 1'b0);
    run_instr(4'h7, 4'h7, 0, 1, 1, 1, 0, 0);
    chk("ifun7", cond, 1'b0);
    run_instr(4'h5, 4'h0, 0, 0, 0, 0, 3, 0);
    run_instr(4'h4, 4'h0, 0, 0, 0, 0, 0, 0);
    chk("timeout_halted", halted, 1'b1);
    do_reset();
    run_instr(4'h0, 4'h0, 0, 0, 0, 0, 0, 0);
    do_reset();
    run_instr(4'hC, 4'h0, 0, 0, 0, 0, 0, 0);
    do_reset();
    run_instr(4'h0, 4'h0, 1, 0, 0, 0, 0, 0);
    do_reset();
    run_instr(4'h9, 4'h0, 0, 0, 0, 0, 4, 0);
    run_instr(4'h8, 4'h0, 0, 0, 0, 0, 2, 1);

    // Abort an instruction stalled in MEMORY.
    do_reset();
    run_instr(4'h6, 4'h0, 0, 0, 1, 1, 0, 0);
    icode = 4'h4; ifun = 4'h0;
    repeat (4) @(negedge clock);
    chk("abort_mem_req", mem_req, 1'b1);
    reset = 1'b1;
    model_reset();
    #1;
    chk("abort_en", en, 6'b0);
    chk("abort_mem_req_rst", mem_req, 1'b0);
    check_arch("abort");
    do_reset();

    for (int i = 0; i < 17; i++) run_instr(4'h1, 4'h0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 150; i++) begin
      logic [3:0] ic;
      int r;
      if (m_halted) do_reset();
      r = $urandom_range(0, 23);
      ic = (r < 16) ? 4'(r) : ((r < 20) ? 4'(r - 12) : 4'(r - 14));
      run_instr(ic, 4'($urandom_range(0, 8)), $urandom_range(0, 19) == 0,
                1'($urandom), 1'($urandom), 1'($urandom),
                $urandom_range(0, 6), $urandom_range(0, 5) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
